bit_change_capture: RTL
=======================

// Module: bit_change_capture
// PURPOSE
//  Monitors a bit bus and records every value change as a timestamped word {ts, bits}.
//  Records are buffered in a FIFO and presented on a valid/ready stream.
//  Counterpart of the CSV-driven timing benches: it captures "timestamp + values" rows from live signals.
//  Sits beside a block under test or in the capture path, feeding a readout/DMA or a bench logger.
// PARAMETERS
//  NBITS      8   width of monitored bus bits_i
//  TS_WIDTH   32  timestamp width; record width = TS_WIDTH+NBITS
//  FIFO_DEPTH 16  record buffer depth, power of 2, >=4
// PORTS
//  clk_i         in   1                single clock, all logic on posedge
//  reset_i       in   1                synchronous, active-high reset
//  enable_i      in   1                capture window; rising edge starts, falling edge stops
//  bits_i        in   NBITS            monitored bus
//  data_o        out  TS_WIDTH+NBITS   record {ts[TS_WIDTH-1:0], bits[NBITS-1:0]}
//  valid_o       out  1                data_o holds a record
//  ready_i       in   1                consumer accepts when valid_o&&ready_i
//  active_o      out  1                1 while in CAPTURE state
//  overflow_o    out  1                sticky: a record was dropped (FIFO full)
//  drop_count_o  out  16               dropped-record count (only with BIT_CAPTURE_DROP_COUNT_EN)
// BEHAVIOUR
//  Reset: state IDLE; FIFO flushed; data_o=0, valid_o=0, active_o=0, overflow_o=0, drop_count_o=0; ts=0; prev=0.
//  FSM: IDLE -> CAPTURE when enable_i=1 and enable_i registered = 0 (rising edge).
//       CAPTURE -> IDLE on the cycle enable_i samples 0; enable_i stays 1 -> no re-arm.
//  Entry cycle (edge detected): ts<=0, overflow_o<=0, drop count<=0; record {0, bits_i} generated unconditionally.
//  In CAPTURE: ts increments by 1 each cycle and saturates at all-ones (no wrap).
//    A record {ts, bits_i} is generated in any cycle where bits_i != prev.
//    prev <= bits_i every cycle.
//  Timestamp semantic: ts = clk cycles since the rising-edge cycle of enable_i.
//  Leaving CAPTURE: no further records. FIFO contents are NOT flushed and drain normally.
//  Re-arm with an undrained FIFO: new records append behind old ones; overflow/count are cleared.
//  Pipeline: generated record written to FIFO at end of the cycle after bits_i was sampled (1 reg stage).
//    With an empty FIFO, valid_o rises 2 cycles after the sampling edge.
//  Stream: first-word-fall-through, registered output.
//    data_o/valid_o held stable while valid_o && !ready_i.
//    Back-to-back pops sustain 1 record/cycle.
//  Full: the write is dropped and overflow_o<=1 (sticky until next arm or reset).
//    If a pop occurs in the same cycle as a write to a full FIFO, the write is accepted and nothing is dropped.
//  Empty + write same cycle: record appears on data_o the next cycle (no bypass).
//  Reset mid-capture or mid-drain: immediate return to reset state; in-flight records lost.
//  Mid-pipeline stop: a record generated in the last CAPTURE cycle is still written.
// CONFIGURATION
//  BIT_CAPTURE_DROP_COUNT_EN defined:
//    drop_count_o increments once per dropped record, saturating at 16'hFFFF.
//    Cleared on arm and on reset.
//  BIT_CAPTURE_DROP_COUNT_EN undefined:
//    drop_count_o tied to 16'h0000 and no counter logic is built.
//    overflow_o is unaffected either way.
// TESTING
//  1 reset_i=1 with enable_i=1 and toggling bits_i -> all outputs 0, no records after release until a fresh enable rise.
//  2 enable rise at ts=0 with bits_i=8'h00; bits_i->8'h05 at ts=3, 8'h07 at ts=4; ready_i=1
//    -> records {0,00},{3,05},{4,07} in order; valid_o 2 cycles after each sample.
//  3 ready_i=0, FIFO_DEPTH=16, bits_i toggles every cycle for 20 cycles
//    -> 16 records kept (the first 16); overflow_o=1; drop_count_o=4 with macro, 0 without.
//  4 FIFO full, then ready_i=1 in a cycle with a new change -> pop and push both happen, no drop counted, order preserved.
//  5 enable_i 1->0 with 5 records queued, then re-arm -> old 5 drain first, new {0,bits} follows;
//    overflow_o cleared at re-arm; ts restarts at 0.
//  6 force ts (TS_WIDTH=4) past 15 with a change at cycles 15 and 20 -> both records carry ts=4'hF.

Source files
------------

// File: rtl/bit_change_capture.sv
// rtl/bit_change_capture.sv - bus change recorder emitting {ts, bits} records on a FWFT stream; optional BIT_CAPTURE_DROP_COUNT_EN
module bit_change_capture #(
    parameter int NBITS      = 8,
    parameter int TS_WIDTH   = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [NBITS-1:0]          bits_i,
    output logic [TS_WIDTH+NBITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      active_o,
    output logic                      overflow_o,
    output logic [15:0]               drop_count_o
);

    localparam int RW = TS_WIDTH + NBITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]         DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]         CNT_ONE   = (AW+1)'(1);
    localparam logic [TS_WIDTH-1:0] TS_MAX    = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                enable_q;
    logic                arm;
    logic                capture;
    logic                gen;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_cur;
    logic [NBITS-1:0]    prev_q;
    logic                rec_valid_q;
    logic [RW-1:0]       rec_data_q;

    logic [RW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_next;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic [AW:0]         avail;
    logic                pop;
    logic                full;
    logic                push;
    logic                drop;

    // Enable history is sampled even during reset so a level held high through reset never looks like a fresh rise.
    always_ff @(posedge clk_i) begin
        enable_q <= enable_i;
    end

    // Next state, arm/capture qualifiers and the timestamp of the current cycle.
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && !enable_q) begin
                    state_d = CAPTURE;
                    arm     = 1'b1;
                end
            end
            CAPTURE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (arm) begin
            ts_cur = '0;
        end else if (ts_q == TS_MAX) begin
            ts_cur = ts_q;
        end else begin
            ts_cur = ts_q + TS_WIDTH'(1);
        end
        gen = arm || (capture && (bits_i != prev_q));
    end

    // Capture state, timestamp, previous-value tracking and the single record stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            prev_q      <= '0;
            rec_valid_q <= 1'b0;
            rec_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= bits_i;
            rec_valid_q <= gen;
            rec_data_q  <= {ts_cur, bits_i};
            if (arm || capture) begin
                ts_q <= ts_cur;
            end
        end
    end

    assign active_o = (state_q == CAPTURE);

    // Occupancy bookkeeping; a write into a full buffer survives only when a pop frees a slot on the same edge.
    always_comb begin
        pop     = valid_o && ready_i;
        full    = (count_q == DEPTH_CNT);
        push    = rec_valid_q && (!full || pop);
        drop    = rec_valid_q && full && !pop;
        rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;
        avail   = pop ? count_q - CNT_ONE : count_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Record storage; contents need no reset because the pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= rec_data_q;
        end
    end

    // Pointers, registered head-of-queue output and sticky overflow; the output loads only entries written on earlier edges.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_next;
            count_q <= count_d;
            valid_o <= (avail != '0);
            if (avail != '0) begin
                data_o <= mem[rd_next];
            end
            if (arm) begin
                overflow_o <= 1'b0;
            end else if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef BIT_CAPTURE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of dropped records, restarted by each arm.
    always_ff @(posedge clk_i) begin
        if (reset_i || arm) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count_o = drop_cnt_q;
`else
    assign drop_count_o = 16'h0000;
`endif

endmodule
